// File: rtl/stack_unit.sv
// Parametrised LIFO with descending stack pointer, flip-flop storage and a
// combinational top-of-stack output, plus occupancy flags and sticky errors.
module stack_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int AF_LVL = DEPTH - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              ovf,
  output logic              unf
);

  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_M1_C = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   AF_C       = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0]   ONE_C      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A_C    = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [ADDR_W:0]   sp_full_s;
  logic [ADDR_W-1:0] top_addr_s;

  // Pointer is derived from the count so the two can never disagree.
  assign sp_full_s  = DEPTH_M1_C - count_q;
  assign sp         = sp_full_s[ADDR_W-1:0];
  assign top_addr_s = sp + ONE_A_C;

  assign count       = count_q;
  assign empty       = (count_q == {(ADDR_W+1){1'b0}});
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign ovf         = ovf_q;
  assign unf         = unf_q;
  assign dout        = empty ? {DATA_W{1'b0}} : mem_q[top_addr_s];

  // Next-state decode of the push/pop strobes.
  always_comb begin
    count_d   = count_q;
    ovf_d     = ovf_q & ~clr_err;
    unf_d     = unf_q & ~clr_err;
    wr_en_s   = 1'b0;
    wr_addr_s = sp;
    case ({push, pop})
      2'b10: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en_s = 1'b1;
          count_d = count_q + ONE_C;
        end
      end
      2'b01: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - ONE_C;
        end
      end
      2'b11: begin
        // Replace top; on an empty stack the pop is the illegal half.
        if (empty) begin
          unf_d   = 1'b1;
          wr_en_s = 1'b1;
          count_d = count_q + ONE_C;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = top_addr_s;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {(ADDR_W+1){1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; writes are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_addr_s] <= din;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit at DEPTH=4, AF_LVL=2.
module tb_stack_unit;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk, rst, push, pop, clr_err;
  logic [DW-1:0] din, dout;
  logic [AW-1:0] sp;
  logic [AW:0]   count;
  logic          empty, full, almost_full, ovf, unf;

  int n_cmp = 0;
  int n_err = 0;

  stack_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .AF_LVL(2)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .dout(dout), .sp(sp), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full),
    .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes, sampled 1 ns after the edge.
  task automatic cyc(input logic p, input logic o, input logic [DW-1:0] d, input logic c);
    push = p; pop = o; din = d; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic [DW-1:0] top,
                           input logic o, input logic u);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".dout"},  32'(dout),  32'(top));
    chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, ".full"},  32'(full),  32'(cnt == 4));
    chk({tag, ".af"},    32'(almost_full), 32'(cnt >= 2));
    chk({tag, ".ovf"},   32'(ovf), 32'(o));
    chk({tag, ".unf"},   32'(unf), 32'(u));
    if (cnt < 4) chk({tag, ".sp"}, 32'(sp), 32'(3 - cnt));
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
    @(posedge clk); #1;
    chk_state("reset", 0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // 1: fill
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'(16'hA1 + i), 1'b0);
      chk_state($sformatf("fill%0d", i), i + 1, 16'(16'hA1 + i), 1'b0, 1'b0);
    end

    // 2: overflow then drain
    cyc(1'b1, 1'b0, 16'h00FF, 1'b0);
    chk_state("ovf", 4, 16'h00A4, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    chk_state("pop1", 3, 16'h00A3, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    chk_state("pop2", 2, 16'h00A2, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    chk_state("pop3", 1, 16'h00A1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    chk_state("pop4", 0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    chk_state("clr_ovf", 0, 16'h0000, 1'b0, 1'b0);

    // 3: underflow, clear, clear colliding with new error
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    chk_state("unf", 0, 16'h0000, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    chk_state("clr_unf", 0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b1);
    chk_state("clr_vs_set", 0, 16'h0000, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 1'b1);

    // 4: replace top
    cyc(1'b1, 1'b0, 16'h0011, 1'b0);
    cyc(1'b1, 1'b0, 16'h0022, 1'b0);
    cyc(1'b1, 1'b1, 16'h0033, 1'b0);
    chk_state("repl", 2, 16'h0033, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    chk_state("repl_pop", 1, 16'h0011, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'h00B2, 1'b0);
    cyc(1'b1, 1'b0, 16'h00B3, 1'b0);
    cyc(1'b1, 1'b0, 16'h00B4, 1'b0);
    chk_state("refill", 4, 16'h00B4, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h00C0, 1'b0);
    chk_state("repl_full", 4, 16'h00C0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    chk_state("repl_full_pop", 3, 16'h00B3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h0, 1'b0);
    chk_state("drain", 0, 16'h0000, 1'b0, 1'b0);

    // 5: push&pop on empty
    cyc(1'b1, 1'b1, 16'h005A, 1'b0);
    chk_state("pp_empty", 1, 16'h005A, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 1'b1);
    chk_state("pp_empty_pop", 0, 16'h0000, 1'b0, 1'b0);

    // 6: async reset mid-cycle while pushing
    cyc(1'b1, 1'b0, 16'h0001, 1'b0);
    cyc(1'b1, 1'b0, 16'h0002, 1'b0);
    cyc(1'b1, 1'b0, 16'h0003, 1'b0);
    cyc(1'b1, 1'b0, 16'h0004, 1'b0);
    cyc(1'b1, 1'b0, 16'h0005, 1'b0);
    chk_state("pre_rst", 4, 16'h0004, 1'b1, 1'b0);
    push = 1'b1; din = 16'h0099;
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_state("rst_held", 0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 16'h0077, 1'b0);
    chk_state("post_rst", 1, 16'h0077, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
